// File: rtl/cntdw_pkg.sv
// rtl/cntdw_pkg.sv - shared types and constants for the HMS countdown controller
//
// Purpose: FSM state encoding and the field widths and limits of the H:M:S count.
// Ports:   none (package).
package cntdw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_t;

  localparam int SEC_W   = 6;
  localparam int MIN_W   = 6;
  localparam int HOUR_W  = 5;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;

endpackage

// File: rtl/hms_digit.sv
// rtl/hms_digit.sv - one wrapping H:M:S field register
//
// Purpose: holds one field of the count. Increment wraps MAX->0 and decrement
//          wraps 0->MAX. Load has priority over inc, and inc over dec.
//          The borrow chain between fields is built by the parent.
// Ports:
//   clk        - clock, posedge
//   resetn     - asynchronous active-low reset, clears value
//   inc        - increment with wrap
//   dec        - decrement with wrap
//   load       - load load_value
//   load_value - value used when load is set
//   value      - current field value
//   is_zero    - value == 0
module hms_digit
  import cntdw_pkg::*;
#(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         inc,
  input  logic         dec,
  input  logic         load,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] value,
  output logic         is_zero
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (inc) begin
      value <= (value == MAX_V) ? '0 : value + 1'b1;
    end else if (dec) begin
      value <= (value == '0) ? MAX_V : value - 1'b1;
    end
  end

  assign is_zero = (value == '0);

endmodule

// File: rtl/hms_cntdw_ctrl.sv
// rtl/hms_cntdw_ctrl.sv - H:M:S countdown control, counting and alarm timing
//
// Purpose: user sets H:M:S in IDLE, start runs a borrow-chained countdown on
//          the 1 Hz tick, start/stop pauses and resumes, and expiry raises a
//          timed alarm that returns to IDLE with the preset restored.
//          Build option CNTDW_AUTO_RELOAD_EN: expiry reloads the preset and keeps
//          running instead of entering ALARM.
// Ports:
//   clk                 - clock, posedge
//   i_countdowner_reset - asynchronous active-low reset
//   i_tick              - 1 Hz enable pulse
//   i_start_stop        - start / pause / resume / alarm acknowledge pulse
//   i_clear             - clear count and preset
//   i_inc_sec/min/hour  - field increment pulses (IDLE only)
//   i_alarm_en          - level, gates o_alarm
//   o_sec, o_min, o_hour- current count
//   o_state             - IDLE=0 RUN=1 PAUSE=2 ALARM=3
//   o_alarm             - buzzer request
//   o_done              - one-cycle expiry pulse
module hms_cntdw_ctrl
  import cntdw_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int HOUR_MAX    = 23
) (
  input  logic              clk,
  input  logic              i_countdowner_reset,
  input  logic              i_tick,
  input  logic              i_start_stop,
  input  logic              i_clear,
  input  logic              i_inc_sec,
  input  logic              i_inc_min,
  input  logic              i_inc_hour,
  input  logic              i_alarm_en,
  output logic [SEC_W-1:0]  o_sec,
  output logic [MIN_W-1:0]  o_min,
  output logic [HOUR_W-1:0] o_hour,
  output logic [1:0]        o_state,
  output logic              o_alarm,
  output logic              o_done
);

  localparam int ACW = $clog2(ALARM_TICKS + 1);

  state_t              state, state_next;
  logic [SEC_W-1:0]    preset_sec, preset_sec_next;
  logic [MIN_W-1:0]    preset_min, preset_min_next;
  logic [HOUR_W-1:0]   preset_hour, preset_hour_next;
  logic [ACW-1:0]      acnt, acnt_next, acnt_inc;
  logic                alarm_next, done_next;

  logic                sec_zero, min_zero, hour_zero, count_zero, expiring;
  logic                load;
  logic [SEC_W-1:0]    load_sec;
  logic [MIN_W-1:0]    load_min;
  logic [HOUR_W-1:0]   load_hour;
  logic                inc_sec, inc_min, inc_hour;
  logic                dec_sec, dec_min, dec_hour;

  // Only the highest-priority event of a cycle acts.
  logic ev_clear, ev_ss, ev_inc, ev_tick;
  assign ev_clear = i_clear;
  assign ev_ss    = !i_clear && i_start_stop;
  assign ev_inc   = !i_clear && !i_start_stop && (i_inc_sec || i_inc_min || i_inc_hour);
  assign ev_tick  = !i_clear && !i_start_stop && !(i_inc_sec || i_inc_min || i_inc_hour)
                    && i_tick;

  assign count_zero = sec_zero && min_zero && hour_zero;
  // The decrement about to happen lands on 00:00:00 exactly when the count is 00:00:01.
  assign expiring   = hour_zero && min_zero && (o_sec == SEC_W'(1));
  assign acnt_inc   = acnt + 1'b1;

  hms_digit #(.W(SEC_W), .MAX(SEC_MAX)) u_sec (
    .clk        (clk),
    .resetn     (i_countdowner_reset),
    .inc        (inc_sec),
    .dec        (dec_sec),
    .load       (load),
    .load_value (load_sec),
    .value      (o_sec),
    .is_zero    (sec_zero)
  );

  hms_digit #(.W(MIN_W), .MAX(MIN_MAX)) u_min (
    .clk        (clk),
    .resetn     (i_countdowner_reset),
    .inc        (inc_min),
    .dec        (dec_min),
    .load       (load),
    .load_value (load_min),
    .value      (o_min),
    .is_zero    (min_zero)
  );

  hms_digit #(.W(HOUR_W), .MAX(HOUR_MAX)) u_hour (
    .clk        (clk),
    .resetn     (i_countdowner_reset),
    .inc        (inc_hour),
    .dec        (dec_hour),
    .load       (load),
    .load_value (load_hour),
    .value      (o_hour),
    .is_zero    (hour_zero)
  );

  always_ff @(posedge clk or negedge i_countdowner_reset) begin
    if (!i_countdowner_reset) begin
      state       <= ST_IDLE;
      preset_sec  <= '0;
      preset_min  <= '0;
      preset_hour <= '0;
      acnt        <= '0;
      o_alarm     <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      state       <= state_next;
      preset_sec  <= preset_sec_next;
      preset_min  <= preset_min_next;
      preset_hour <= preset_hour_next;
      acnt        <= acnt_next;
      o_alarm     <= alarm_next;
      o_done      <= done_next;
    end
  end

  always_comb begin
    state_next       = state;
    preset_sec_next  = preset_sec;
    preset_min_next  = preset_min;
    preset_hour_next = preset_hour;
    acnt_next        = acnt;
    alarm_next       = 1'b0;
    done_next        = 1'b0;
    load             = 1'b0;
    load_sec         = preset_sec;
    load_min         = preset_min;
    load_hour        = preset_hour;
    inc_sec          = 1'b0;
    inc_min          = 1'b0;
    inc_hour         = 1'b0;
    dec_sec          = 1'b0;
    dec_min          = 1'b0;
    dec_hour         = 1'b0;

    if (ev_clear) begin
      load             = 1'b1;
      load_sec         = '0;
      load_min         = '0;
      load_hour        = '0;
      preset_sec_next  = '0;
      preset_min_next  = '0;
      preset_hour_next = '0;
      acnt_next        = '0;
      state_next       = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ev_inc) begin
            inc_sec  = i_inc_sec;
            inc_min  = i_inc_min;
            inc_hour = i_inc_hour;
          end else if (ev_ss && !count_zero) begin
            preset_sec_next  = o_sec;
            preset_min_next  = o_min;
            preset_hour_next = o_hour;
            state_next       = ST_RUN;
          end
        end
        ST_RUN: begin
          if (ev_ss) begin
            state_next = ST_PAUSE;
          end else if (ev_tick) begin
            // Seconds always step; wrap 0->59 supplies the borrowed 59.
            dec_sec  = 1'b1;
            dec_min  = sec_zero;
            dec_hour = sec_zero && min_zero;
            if (expiring) begin
              done_next = 1'b1;
`ifdef CNTDW_AUTO_RELOAD_EN
              // Load overrides the decrement inside each digit.
              load = 1'b1;
`else
              state_next = ST_ALARM;
              acnt_next  = '0;
              alarm_next = i_alarm_en;
`endif
            end
          end
        end
        ST_PAUSE: begin
          if (ev_ss) begin
            state_next = ST_RUN;
          end
        end
        ST_ALARM: begin
          alarm_next = i_alarm_en;
          if (ev_ss || (ev_tick && (acnt_inc == ACW'(ALARM_TICKS)))) begin
            state_next = ST_IDLE;
            load       = 1'b1;
            acnt_next  = '0;
            alarm_next = 1'b0;
          end else if (ev_tick) begin
            acnt_next = acnt_inc;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hms_cntdw_ctrl.sv
// tb/tb_hms_cntdw_ctrl.sv - directed vector bench for hms_cntdw_ctrl
module tb_hms_cntdw_ctrl;

  localparam int AT = 10;

  logic       clk = 1'b0;
  logic       rstn;
  logic       tick, ss, clr, isec, imin, ihour, aen;
  logic [5:0] sec, min;
  logic [4:0] hour;
  logic [1:0] st;
  logic       alarm, done;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int c, s_s, is, im, ih, tk, ae;
    int sec, min, hour, st, al, dn;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  hms_cntdw_ctrl #(.ALARM_TICKS(AT), .HOUR_MAX(23)) dut (
    .clk                 (clk),
    .i_countdowner_reset (rstn),
    .i_tick              (tick),
    .i_start_stop        (ss),
    .i_clear             (clr),
    .i_inc_sec           (isec),
    .i_inc_min           (imin),
    .i_inc_hour          (ihour),
    .i_alarm_en          (aen),
    .o_sec               (sec),
    .o_min               (min),
    .o_hour              (hour),
    .o_state             (st),
    .o_alarm             (alarm),
    .o_done              (done)
  );

  task automatic add(input int c, s_s, is, im, ih, tk, ae,
                     input int e_sec, e_min, e_hour, e_st, e_al, e_dn);
    vec_t v;
    v.c = c; v.s_s = s_s; v.is = is; v.im = im; v.ih = ih; v.tk = tk; v.ae = ae;
    v.sec = e_sec; v.min = e_min; v.hour = e_hour; v.st = e_st; v.al = e_al; v.dn = e_dn;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s vec=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input int e_sec, e_min, e_hour, e_st, e_al, e_dn);
    chk("sec", idx, int'(sec), e_sec);
    chk("min", idx, int'(min), e_min);
    chk("hour", idx, int'(hour), e_hour);
    chk("state", idx, int'(st), e_st);
    chk("alarm", idx, int'(alarm), e_al);
    chk("done", idx, int'(done), e_dn);
  endtask

  initial begin
    rstn = 1'b0; tick = 0; ss = 0; clr = 0; isec = 0; imin = 0; ihour = 0; aen = 1;

    // Build vectors: {clr, ss, isec, imin, ihour, tick, aen} -> {sec, min, hour, st, alarm, done}
    for (int k = 1; k <= 3; k++) add(0,0,1,0,0,0,1, k,0,0,0,0,0);
    add(0,0,0,1,0,0,1, 3,1,0,0,0,0);
    add(0,1,0,0,0,0,1, 3,1,0,1,0,0);
    add(0,0,0,0,0,1,1, 2,1,0,1,0,0);
    add(0,0,0,0,0,1,1, 1,1,0,1,0,0);
    add(0,0,0,0,0,1,1, 0,1,0,1,0,0);
    add(0,0,0,0,0,1,1, 59,0,0,1,0,0);
    add(1,0,0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,0,0,1,0,1, 0,0,1,0,0,0);
    add(0,1,0,0,0,0,1, 0,0,1,1,0,0);
    add(0,0,0,0,0,1,1, 59,59,0,1,0,0);
    add(1,0,0,0,0,0,1, 0,0,0,0,0,0);
    add(0,0,1,0,0,1,1, 1,0,0,0,0,0);   // inc beats tick
    add(0,0,1,0,0,0,1, 2,0,0,0,0,0);
`ifndef CNTDW_AUTO_RELOAD_EN
    add(0,1,0,0,0,0,1, 2,0,0,1,0,0);
    add(0,0,0,0,0,1,1, 1,0,0,1,0,0);
    add(0,0,0,0,0,1,1, 0,0,0,3,1,1);
    add(0,0,0,0,0,0,1, 0,0,0,3,1,0);
    for (int k = 1; k <= AT; k++) begin
      if (k < AT) add(0,0,0,0,0,1,1, 0,0,0,3,1,0);
      else        add(0,0,0,0,0,1,1, 2,0,0,0,0,0);
    end
    add(0,1,0,0,0,0,1, 2,0,0,1,0,0);
    add(0,0,0,0,0,1,1, 1,0,0,1,0,0);
    add(0,0,0,0,0,1,1, 0,0,0,3,1,1);
    add(0,0,0,0,0,1,0, 0,0,0,3,0,0);
    add(0,0,0,0,0,1,1, 0,0,0,3,1,0);
    add(0,0,0,0,0,1,1, 0,0,0,3,1,0);
    add(0,1,0,0,0,0,1, 2,0,0,0,0,0);
`else
    add(0,0,1,0,0,0,1, 3,0,0,0,0,0);
    add(0,1,0,0,0,0,1, 3,0,0,1,0,0);
    for (int r = 0; r < 2; r++) begin
      add(0,0,0,0,0,1,1, 2,0,0,1,0,0);
      add(0,0,0,0,0,1,1, 1,0,0,1,0,0);
      add(0,0,0,0,0,1,1, 3,0,0,1,0,1);
    end
    add(0,0,0,0,0,0,1, 3,0,0,1,0,0);
`endif
    add(1,0,0,0,0,0,1, 0,0,0,0,0,0);
    for (int k = 1; k <= 30; k++) add(0,0,1,0,0,0,1, k,0,0,0,0,0);
    add(0,1,0,0,0,0,1, 30,0,0,1,0,0);
    add(0,0,1,0,0,0,1, 30,0,0,1,0,0);  // inc ignored in RUN
    add(0,1,0,0,0,0,1, 30,0,0,2,0,0);
    for (int k = 0; k < 5; k++) add(0,0,0,0,0,1,1, 30,0,0,2,0,0);
    add(0,0,0,1,0,0,1, 30,0,0,2,0,0);  // inc ignored in PAUSE
    add(0,1,0,0,0,0,1, 30,0,0,1,0,0);
    add(0,0,0,0,0,1,1, 29,0,0,1,0,0);
    add(0,1,0,0,0,1,1, 29,0,0,2,0,0);  // tick dropped under start_stop
    add(0,1,0,0,0,0,1, 29,0,0,1,0,0);
    add(1,1,0,0,0,1,1, 0,0,0,0,0,0);
    add(0,1,0,0,0,0,1, 0,0,0,0,0,0);   // start at zero ignored
    for (int k = 1; k <= 60; k++) add(0,0,1,0,0,0,1, k % 60,0,0,0,0,0);
    for (int k = 1; k <= 24; k++) add(0,0,0,0,1,0,1, 0,0,k % 24,0,0,0);

    // Reset state
    #12;
    chk_all(-1, 0,0,0,0,0,0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      clr = vecs[i].c[0]; ss = vecs[i].s_s[0]; isec = vecs[i].is[0];
      imin = vecs[i].im[0]; ihour = vecs[i].ih[0]; tick = vecs[i].tk[0];
      aen = vecs[i].ae[0];
      @(posedge clk);
      #1;
      clr = 0; ss = 0; isec = 0; imin = 0; ihour = 0; tick = 0;
      chk_all(i, vecs[i].sec, vecs[i].min, vecs[i].hour, vecs[i].st, vecs[i].al, vecs[i].dn);
    end

    // Mid-run reset coincident with the expiring tick: abort, no done.
    @(negedge clk); clr = 1;
    @(negedge clk); clr = 0; isec = 1;
    @(negedge clk); isec = 0; ss = 1;
    @(posedge clk); #1; ss = 0;
    chk("pre_reset_state", 900, int'(st), 1);
    @(negedge clk); tick = 1; rstn = 1'b0;
    #1;
    chk_all(901, 0,0,0,0,0,0);
    @(posedge clk); #1;
    tick = 0;
    chk_all(902, 0,0,0,0,0,0);
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;
    chk_all(903, 0,0,0,0,0,0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
